signed_serial_addsub: RTL and testbench

- Sequential arithmetic core of the signed calculator.
- Takes two WIDTH-bit two's-complement operands and an add/sub select, and processes them LSB-first, one bit per clock.
- Each bit goes through the per-bit sum/carry adder cells, with a registered carry between bits.
- Registers the final result and status flags for the display/output stage downstream.

---
 rtl/signed_serial_addsub_if.sv | 27 ++
 rtl/signed_serial_addsub.sv | 127 ++++++++++++
 tb/tb_signed_serial_addsub.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/signed_serial_addsub_if.sv
// Request/response bundle for the bit-serial signed add/subtract core.
// The master issues operations; the slave (the core) returns the result and flags.
interface signed_serial_addsub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             neg;

  modport master (
    output start, op, a, b,
    input  busy, done, result, carry_out, overflow, zero, neg
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, carry_out, overflow, zero, neg
  );
endinterface

// File: rtl/signed_serial_addsub.sv
// Bit-serial two's-complement adder/subtractor: one bit per clock, LSB first,
// with the result and status flags registered together on completion.
module signed_serial_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  signed_serial_addsub_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_carry_out;
  logic             r_overflow;
  logic             r_zero;
  logic             r_neg;

  logic             w_s;
  logic             w_c_nxt;
  logic             w_last;
  logic             w_accept;
  logic             w_finish;
  logic [WIDTH-1:0] w_acc_nxt;

  // Full-adder cell on the current LSBs with the registered carry
  assign w_s       = r_sa[0] ^ r_sb[0] ^ r_c;
  assign w_c_nxt   = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_c) | (r_sb[0] & r_c);
  assign w_acc_nxt = {w_s, r_acc[WIDTH-1:1]};
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_last) begin
          w_finish    = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand shifters, carry flop, counter and the registered result/flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa        <= '0;
      r_sb        <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_c         <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != IDLE);
      r_done <= (w_state_nxt == DONE);
      if (w_accept) begin
        // Subtract is a + ~b + 1: invert b and seed the carry with op
        r_sa  <= bus.a;
        r_sb  <= bus.b ^ {WIDTH{bus.op}};
        r_c   <= bus.op;
        r_cnt <= '0;
      end else if (r_state == SHIFT) begin
        r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
        r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
        r_c   <= w_c_nxt;
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_finish) begin
        // r_c here is still the carry into the MSB
        r_result    <= w_acc_nxt;
        r_carry_out <= w_c_nxt;
        r_overflow  <= r_c ^ w_c_nxt;
        r_zero      <= (w_acc_nxt == '0);
        r_neg       <= w_acc_nxt[WIDTH-1];
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.result    = r_result;
  assign bus.carry_out = r_carry_out;
  assign bus.overflow  = r_overflow;
  assign bus.zero      = r_zero;
  assign bus.neg       = r_neg;

endmodule

// File: tb/tb_signed_serial_addsub.sv
// Directed bench for signed_serial_addsub at WIDTH=8: vector table plus
// hand-written sequences for busy handling and mid-operation reset.
module tb_signed_serial_addsub;

  localparam int unsigned WIDTH = 8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       op;
    logic [7:0] res;
    logic       c;
    logic       v;
    logic       z;
    logic       n;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  signed_serial_addsub_if #(.WIDTH(WIDTH)) bus ();

  signed_serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] pack_out();
    return {bus.result, bus.carry_out, bus.overflow, bus.zero, bus.neg};
  endfunction

  // Issue one operation, check latency, output stability during SHIFT,
  // the result/flags and that done is a single-cycle pulse.
  task automatic run_op(input vec_t v, input string name);
    logic [11:0] prev;
    int          lat;
    logic        unstable;
    prev     = pack_out();
    lat      = 0;
    unstable = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = v.a;
    bus.b     = v.b;
    bus.op    = v.op;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = ~v.a;
    bus.b     = ~v.b;
    bus.op    = ~v.op;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = n;
        break;
      end
      if (pack_out() !== prev) unstable = 1'b1;
    end
    chk({name, " latency"}, 32'(lat), 32'd9);
    chk({name, " stable"}, 32'(unstable), 32'd0);
    chk({name, " res/c/v/z/n"}, 32'(pack_out()), 32'({v.res, v.c, v.v, v.z, v.n}));
    @(negedge clk);
    chk({name, " done/busy after"}, 32'({bus.done, bus.busy}), 32'd0);
  endtask

  initial begin
    vec_t vecs[10];
    int   n_done;
    int   done_at[3];
    logic [11:0] held;
    logic        unstable;
    logic        saw_done;

    checks = 0;
    errors = 0;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h64, 8'h32, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{8'h00, 8'h80, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    chk("reset outputs", 32'(pack_out()), 32'd0);
    chk("reset busy/done", 32'({bus.busy, bus.done}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // start held high with operands changed right after acceptance
    held     = pack_out();
    unstable = 1'b0;
    n_done   = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 8'h11;
    bus.b     = 8'h22;
    @(posedge clk);
    #1;
    bus.a = 8'h7F;
    bus.b = 8'h7F;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 30) bus.start = 1'b0;
      if (bus.done) begin
        if (n_done < 3) done_at[n_done] = n;
        if (n_done == 0)
          chk("held first res/c/v/z/n", 32'(pack_out()), 32'({8'h33, 1'b0, 1'b0, 1'b0, 1'b0}));
        if (n_done == 1)
          chk("held second res/c/v/z/n", 32'(pack_out()), 32'({8'hFE, 1'b0, 1'b1, 1'b0, 1'b1}));
        n_done++;
        held = pack_out();
      end else if (pack_out() !== held) begin
        unstable = 1'b1;
      end
      if (n == 10) chk("held idle gap busy", 32'(bus.busy), 32'd0);
      if (n == 5)  chk("held shift busy", 32'(bus.busy), 32'd1);
    end
    chk("held done count", 32'(n_done), 32'd3);
    if (n_done == 3) begin
      chk("held done0 cycle", 32'(done_at[0]), 32'd9);
      chk("held done1 cycle", 32'(done_at[1]), 32'd19);
      chk("held done2 cycle", 32'(done_at[2]), 32'd29);
    end
    chk("held outputs stable", 32'(unstable), 32'd0);
    repeat (2) @(negedge clk);
    chk("held released idle", 32'({bus.busy, bus.done}), 32'd0);

    // reset four cycles into an operation
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 8'h10;
    bus.b     = 8'h20;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre-reset busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("async reset outputs", 32'(pack_out()), 32'd0);
    chk("async reset busy/done", 32'({bus.busy, bus.done}), 32'd0);
    saw_done = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (n == 2) rst = 1'b0;
      if (bus.done) saw_done = 1'b1;
    end
    chk("no done after reset", 32'(saw_done), 32'd0);
    run_op('{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0}, "post-reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
